// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding, status
// counter width and small helpers for counter sizing and saturation.
package pll_seq_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_e;

  // Largest of three cycle parameters; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Status counters stick at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Status export of the PLL reset sequencer towards the Nios PIO.
// The sequencer drives it through the master modport, the PIO reads it
// through the slave modport.
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic               lock_lost;
  logic [STATE_W-1:0] state_o;
  logic [CNT_W-1:0]   retry_count;
  logic [CNT_W-1:0]   loss_count;

  modport master (output lock_lost, output state_o, output retry_count, output loss_count);
  modport slave  (input  lock_lost, input  state_o, input  retry_count, input  loss_count);

endinterface

// File: rtl/pll_seq_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit. Clears to 0
// on reset so an unknown input reads as "not asserted" until proven.
module pll_seq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a qualified lock,
// then releases the downstream system reset. Lock timeouts and lock losses
// re-reset the PLL and are counted for software.
// Optional build macro PLL_SEQ_RETRY_LIMIT_EN: after MAX_RETRIES consecutive
// timeouts the sequencer parks in FAIL (PLL held in reset) until reset_n.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_reset_n,
  pll_reset_sequencer_if.master status
);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam bit RETRY_LIMIT = 1'b1;
`else
  localparam bit RETRY_LIMIT = 1'b0;
`endif

  localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  localparam logic [TW-1:0]    RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]    STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX   = CNT_W'(MAX_RETRIES);

  logic            locked_s;
  seq_state_e      state_r, state_nxt_s;
  logic [TW-1:0]   cnt_r, cnt_nxt_s;
  logic [CNT_W-1:0] retry_r, retry_nxt_s, retry_inc_s;
  logic [CNT_W-1:0] loss_r, loss_nxt_s;
  logic            lock_lost_nxt_s;
  logic            pll_rst_r, sys_reset_n_r, lock_lost_r;

  pll_seq_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  assign retry_inc_s = sat_inc(retry_r);

  // Next-state, status-counter and cycle-counter decisions from locked_s.
  always_comb begin
    state_nxt_s     = state_r;
    retry_nxt_s     = retry_r;
    loss_nxt_s      = loss_r;
    lock_lost_nxt_s = 1'b0;
    case (state_r)
      PLL_RESET: begin
        if (cnt_r == RST_LAST) begin
          state_nxt_s = WAIT_LOCK;
        end else begin
          state_nxt_s = PLL_RESET;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt_s = STABLE;
        end else if (cnt_r == TO_LAST) begin
          retry_nxt_s = retry_inc_s;
          if (RETRY_LIMIT && (retry_inc_s >= RETRY_MAX)) begin
            state_nxt_s = FAIL;
          end else begin
            state_nxt_s = PLL_RESET;
          end
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        // A dropout sends us back to waiting with a fresh timeout; it is
        // not a timeout and therefore not a retry.
        if (!locked_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = RUN;
          retry_nxt_s = '0;
        end else begin
          state_nxt_s = STABLE;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt_s     = PLL_RESET;
          loss_nxt_s      = sat_inc(loss_r);
          lock_lost_nxt_s = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FAIL: begin
        if (RETRY_LIMIT) begin
          state_nxt_s = FAIL;
        end else begin
          state_nxt_s = PLL_RESET;
        end
      end
      default: begin
        state_nxt_s = PLL_RESET;
      end
    endcase

    // One shared counter, restarted on every state change; idle in RUN/FAIL.
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = '0;
    end else if ((state_r == RUN) || (state_r == FAIL)) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + TW'(1);
    end
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= PLL_RESET;
      cnt_r         <= '0;
      retry_r       <= '0;
      loss_r        <= '0;
      pll_rst_r     <= 1'b1;
      sys_reset_n_r <= 1'b0;
      lock_lost_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      retry_r       <= retry_nxt_s;
      loss_r        <= loss_nxt_s;
      pll_rst_r     <= (state_nxt_s == PLL_RESET) || (state_nxt_s == FAIL);
      sys_reset_n_r <= (state_nxt_s == RUN);
      lock_lost_r   <= lock_lost_nxt_s;
    end
  end

  assign pll_rst            = pll_rst_r;
  assign sys_reset_n        = sys_reset_n_r;
  assign status.lock_lost   = lock_lost_r;
  assign status.state_o     = state_r;
  assign status.retry_count = retry_r;
  assign status.loss_count  = loss_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with RST_CYCLES=4,
// LOCK_TIMEOUT=32, STABLE_CYCLES=8, SYNC_STAGES=2, MAX_RETRIES=4.
// Vector records hold the pll_locked value for N cycles together with the
// outputs expected after each of those clock edges.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic       sysn;
    logic       lost;
    logic [7:0] retry;
    logic [7:0] loss;
  } exp_t;

  typedef struct {
    int   n;
    logic lk;
    exp_t e;
  } vec_t;

  logic clk;
  logic reset_n;
  logic pll_locked;
  logic pll_rst;
  logic sys_reset_n;

  pll_reset_sequencer_if st_if ();

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (2),
    .MAX_RETRIES   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .status      (st_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic exp_t mk(input seq_state_e st, input logic prst, input logic sysn,
                              input logic lost, input int retry, input int loss);
    exp_t e;
    e.st    = st;
    e.prst  = prst;
    e.sysn  = sysn;
    e.lost  = lost;
    e.retry = 8'(retry);
    e.loss  = 8'(loss);
    return e;
  endfunction

  function automatic void add(input int n, input logic lk, input seq_state_e st,
                              input logic prst, input logic sysn, input logic lost,
                              input int retry, input int loss);
    vec_t v;
    v.n  = n;
    v.lk = lk;
    v.e  = mk(st, prst, sysn, lost, retry, loss);
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag);
    exp_t e;
    exp_t a;
    a.st    = st_if.state_o;
    a.prst  = pll_rst;
    a.sysn  = sys_reset_n;
    a.lost  = st_if.lock_lost;
    a.retry = st_if.retry_count;
    a.loss  = st_if.loss_count;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got st=%0d prst=%b sysn=%b lost=%b retry=%0d loss=%0d",
               tag, a.st, a.prst, a.sysn, a.lost, a.retry, a.loss);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got st=%0d prst=%b sysn=%b lost=%b retry=%0d loss=%0d, want st=%0d prst=%b sysn=%b lost=%b retry=%0d loss=%0d",
                 tag, $time, a.st, a.prst, a.sysn, a.lost, a.retry, a.loss,
                 e.st, e.prst, e.sysn, e.lost, e.retry, e.loss);
      end
    end
  endtask

  // Drive one record: hold lk for n cycles, checking outputs after each edge.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        pll_locked = vecs[i].lk;
        exp_q.push_back(vecs[i].e);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s[%0d.%0d]", tag, i, c));
      end
    end
    vecs.delete();
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(mk(PLL_RESET, 1'b1, 1'b0, 1'b0, 0, 0));
    check(tag);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(mk(PLL_RESET, 1'b1, 1'b0, 1'b0, 0, 0));
    check("reset_state");
    reset_n = 1'b1;

    // Lock high from release: 4 reset cycles, 1 wait, 8 stable, then RUN.
    add(3, 1'b1, PLL_RESET, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1, 1'b1, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);
    add(8, 1'b1, STABLE,    1'b0, 1'b0, 1'b0, 0, 0);
    add(3, 1'b1, RUN,       1'b0, 1'b1, 1'b0, 0, 0);
    // Lock loss in RUN seen after the synchronizer delay.
    add(2, 1'b0, RUN,       1'b0, 1'b1, 1'b0, 0, 0);
    add(1, 1'b0, PLL_RESET, 1'b1, 1'b0, 1'b1, 0, 1);
    add(3, 1'b0, PLL_RESET, 1'b1, 1'b0, 1'b0, 0, 1);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    for (int k = 0; k < 3; k++) begin
      add(32, 1'b0, WAIT_LOCK, 1'b0, 1'b0, 1'b0, k, 1);
      add(4,  1'b0, PLL_RESET, 1'b1, 1'b0, 1'b0, k + 1, 1);
    end
    add(32, 1'b0, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 3, 1);
    add(5,  1'b0, FAIL,      1'b1, 1'b0, 1'b0, 4, 1);
    add(12, 1'b1, FAIL,      1'b1, 1'b0, 1'b0, 4, 1);
    run_vecs("lock_then_fail");
    async_reset_check("reset_in_fail");
`else
    // Lock held low: 36-cycle retry loop, retry_count saturating at 255.
    for (int k = 0; k < 260; k++) begin
      add(32, 1'b0, WAIT_LOCK, 1'b0, 1'b0, 1'b0, (k > 255) ? 255 : k, 1);
      add(4,  1'b0, PLL_RESET, 1'b1, 1'b0, 1'b0, (k + 1 > 255) ? 255 : k + 1, 1);
    end
    // Lock returns: qualify, RUN clears retry_count.
    add(2, 1'b1, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 255, 1);
    add(8, 1'b1, STABLE,    1'b0, 1'b0, 1'b0, 255, 1);
    add(2, 1'b1, RUN,       1'b0, 1'b1, 1'b0, 0, 1);
    add(2, 1'b0, RUN,       1'b0, 1'b1, 1'b0, 0, 1);
    add(1, 1'b0, PLL_RESET, 1'b1, 1'b0, 1'b1, 0, 2);
    add(3, 1'b1, PLL_RESET, 1'b1, 1'b0, 1'b0, 0, 2);
    add(1, 1'b1, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 2);
    add(3, 1'b1, STABLE,    1'b0, 1'b0, 1'b0, 0, 2);
    run_vecs("lock_retry_loss");
    async_reset_check("reset_mid_stable");
`endif

    // Second run: 3-cycle dropout during STABLE restarts qualification.
    @(negedge clk);
    pll_locked = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    add(3, 1'b1, PLL_RESET, 1'b1, 1'b0, 1'b0, 0, 0);
    add(1, 1'b1, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);
    add(2, 1'b1, STABLE,    1'b0, 1'b0, 1'b0, 0, 0);
    add(2, 1'b0, STABLE,    1'b0, 1'b0, 1'b0, 0, 0);
    add(1, 1'b0, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);
    add(2, 1'b1, WAIT_LOCK, 1'b0, 1'b0, 1'b0, 0, 0);
    add(8, 1'b1, STABLE,    1'b0, 1'b0, 1'b0, 0, 0);
    add(2, 1'b1, RUN,       1'b0, 1'b1, 1'b0, 0, 0);
    run_vecs("stable_dropout");
    async_reset_check("reset_in_run");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL leftover: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
